// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential array multiplier.
//   state_e     : controller state encoding (IDLE, BUSY, DONE)
//   steps()     : number of BUSY cycles for a given width/radix
//   cnt_bits()  : counter width for n states, never less than 1
//   neg_w()     : two's-complement negation modulo 2^width
//   abs_w()     : magnitude of a width-bit value (identity when unsigned)
// Helpers work on MAX_W-bit containers; callers zero-extend in and size-cast out.
package mult_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int steps(input int width, input int radix);
    return width / radix;
  endfunction

  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_W-1:0] width_mask(input int width);
    return (width >= MAX_W) ? {MAX_W{1'b1}} : ((64'd1 << width) - 64'd1);
  endfunction

  function automatic logic [MAX_W-1:0] neg_w(input logic [MAX_W-1:0] x, input int width);
    return (~x + 64'd1) & width_mask(width);
  endfunction

  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] x, input int width,
                                             input logic is_signed);
    return (is_signed && x[width-1]) ? neg_w(x, width) : (x & width_mask(width));
  endfunction

endpackage

// File: rtl/mult_array_slice.sv
// One combinational slice of the array multiplier.
//   acc_in  : running 2*WIDTH-bit accumulator
//   a       : WIDTH-bit multiplicand magnitude
//   b_slice : RADIX multiplier bits retired in this slice
//   shift   : bit weight of b_slice[0] within the full multiplier
//   acc_out : acc_in + ((a * b_slice) << shift)
// Each multiplier bit gates a row of AND cells; rows are summed one after
// another at increasing weight, then the slice result is added into acc_in.
module mult_array_slice #(
  parameter int WIDTH = 16,
  parameter int RADIX = 4,
  parameter int SH_W  = 6
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   a,
  input  logic [RADIX-1:0]   b_slice,
  input  logic [SH_W-1:0]    shift,
  output logic [2*WIDTH-1:0] acc_out
);

  localparam int PW    = WIDTH + RADIX;
  localparam int ACC_W = 2 * WIDTH;

  logic [PW-1:0]    pp_s;
  logic [PW-1:0]    row_sum_s;
  logic [ACC_W-1:0] slice_ext_s;

  // AND-gate partial-product rows, accumulated row by row
  always_comb begin
    row_sum_s = {PW{1'b0}};
    pp_s      = {PW{1'b0}};
    for (int r = 0; r < RADIX; r++) begin
      pp_s             = {PW{1'b0}};
      pp_s[r +: WIDTH] = a & {WIDTH{b_slice[r]}};
      row_sum_s        = row_sum_s + pp_s;
    end
  end

  // Place the slice product at its weight and add it into the accumulator
  always_comb begin
    slice_ext_s           = {ACC_W{1'b0}};
    slice_ext_s[PW-1:0]   = row_sum_s;
    acc_out               = acc_in + (slice_ext_s << shift);
  end

endmodule

// File: rtl/mult_seq_array.sv
// Iterative WIDTH x WIDTH array multiplier, signed or unsigned per operation.
// Operands are converted to magnitudes on accept; each BUSY cycle retires
// RADIX multiplier bits through one mult_array_slice; the sign is applied to
// the final sum as it is written into P.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   A, B, is_signed      : operands, sampled on the accept edge only
//   out_valid / out_ready: result handshake (valid only in DONE)
//   P                    : 2*WIDTH-bit product, held until the next result
module mult_seq_array
  import mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int RADIX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P
);

  localparam int STEPS = steps(WIDTH, RADIX);
  localparam int CNT_W = cnt_bits(STEPS);
  localparam int ACC_W = 2 * WIDTH;
  localparam int SH_W  = $clog2(ACC_W) + 1;

  generate
    if ((WIDTH % RADIX) != 0 || ACC_W > MAX_W) begin : g_bad_params
      $error("mult_seq_array: WIDTH must be a multiple of RADIX and at most MAX_W/2");
    end
  endgenerate

  state_e            state_r;
  state_e            state_next_s;
  logic [CNT_W-1:0]  step_r;
  logic [SH_W-1:0]   shift_r;
  logic [WIDTH-1:0]  a_mag_r;
  logic [WIDTH-1:0]  b_sh_r;
  logic              neg_r;
  logic [ACC_W-1:0]  acc_r;
  logic [ACC_W-1:0]  p_r;

  logic              in_ready_s;
  logic              out_valid_s;
  logic              accept_s;
  logic              last_step_s;
  logic [WIDTH-1:0]  a_mag_s;
  logic [WIDTH-1:0]  b_mag_s;
  logic              neg_s;
  logic [ACC_W-1:0]  acc_next_s;
  logic [ACC_W-1:0]  p_fix_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_next_s = BUSY;
        else          state_next_s = IDLE;
      end
      BUSY: begin
        if (last_step_s) state_next_s = DONE;
        else             state_next_s = BUSY;
      end
      DONE: begin
        if (out_ready) state_next_s = IDLE;
        else           state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_r)
      IDLE:    in_ready_s  = 1'b1;
      BUSY:    in_ready_s  = 1'b0;
      DONE:    out_valid_s = 1'b1;
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign P         = p_r;

  // Operand conditioning: magnitudes, result sign, step bookkeeping
  always_comb begin
    accept_s    = in_valid & in_ready_s;
    last_step_s = (step_r == CNT_W'(STEPS - 1));
    a_mag_s     = WIDTH'(abs_w(MAX_W'(A), WIDTH, is_signed));
    b_mag_s     = WIDTH'(abs_w(MAX_W'(B), WIDTH, is_signed));
    neg_s       = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
  end

  mult_array_slice #(
    .WIDTH (WIDTH),
    .RADIX (RADIX),
    .SH_W  (SH_W)
  ) u_slice (
    .acc_in  (acc_r),
    .a       (a_mag_r),
    .b_slice (b_sh_r[RADIX-1:0]),
    .shift   (shift_r),
    .acc_out (acc_next_s)
  );

  // Sign fix-up of the final sum, modulo 2^ACC_W
  always_comb begin
    if (neg_r) p_fix_s = ACC_W'(neg_w(MAX_W'(acc_next_s), ACC_W));
    else       p_fix_s = acc_next_s;
  end

  // Operand, accumulator and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_r  <= {CNT_W{1'b0}};
      shift_r <= {SH_W{1'b0}};
      a_mag_r <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      neg_r   <= 1'b0;
      acc_r   <= {ACC_W{1'b0}};
      p_r     <= {ACC_W{1'b0}};
    end else if (accept_s) begin
      step_r  <= {CNT_W{1'b0}};
      shift_r <= {SH_W{1'b0}};
      a_mag_r <= a_mag_s;
      b_sh_r  <= b_mag_s;
      neg_r   <= neg_s;
      acc_r   <= {ACC_W{1'b0}};
    end else if (state_r == BUSY) begin
      step_r  <= step_r + CNT_W'(1);
      shift_r <= shift_r + SH_W'(RADIX);
      b_sh_r  <= b_sh_r >> RADIX;
      acc_r   <= acc_next_s;
      if (last_step_s) begin
        p_r <= p_fix_s;
      end else begin
        p_r <= p_r;
      end
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: tb/tb_mult_seq_array.sv
// Self-checking bench for mult_seq_array: directed corner products, backpressure,
// ignored mid-operation requests, asynchronous reset abort, and randomized
// operations checked against an arithmetic reference product.
module tb_mult_seq_array;

  localparam int W     = 16;
  localparam int R     = 4;
  localparam int STEPS = W / R;
  localparam int N_RND = 2000;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           is_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] P;

  int n_checks;
  int n_errors;

  mult_seq_array #(.WIDTH(W), .RADIX(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product: interpret operands as integers, multiply, keep 2W bits.
  function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic [63:0] va;
    logic [63:0] vb;
    logic [63:0] m;
    va = 64'(a);
    vb = 64'(b);
    if (s && a[W-1]) va = va - (64'd1 << W);
    if (s && b[W-1]) vb = vb - (64'd1 << W);
    m = (2 * W >= 64) ? {64{1'b1}} : ((64'd1 << (2 * W)) - 64'd1);
    return (va * vb) & m;
  endfunction

  // One full operation: accept, latency, optional stall with noise, handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int stall, input logic [63:0] exp, input string tag);
    int n;
    int lat;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    A = a; B = b; is_signed = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); is_signed = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 64) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(STEPS));
    check({tag, "_P"}, 64'(P), exp);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      A = W'($urandom); B = W'($urandom);
      out_ready = 1'b0;
      @(posedge clk); #1;
      check({tag, "_hold_v"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_P"}, 64'(P), exp);
      check({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drain_v"}, 64'(out_valid), 64'd0);
    check({tag, "_drain_rdy"}, 64'(in_ready), 64'd1);
    check({tag, "_keep_P"}, 64'(P), exp);
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] p;
    string          tag;
  } vec_t;

  vec_t dir_q[$];

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    is_signed = 1'b0;
    out_ready = 1'b0;

    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_P", 64'(P), 64'd0);
    #11 rst_n = 1'b1;

    dir_q.push_back('{16'h0001, 16'h0001, 1'b0, 32'h00000001, "u_1x1"});
    dir_q.push_back('{16'h0002, 16'h0003, 1'b0, 32'h00000006, "u_2x3"});
    dir_q.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "u_max2"});
    dir_q.push_back('{16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF, "u_maxx1"});
    dir_q.push_back('{16'd756,  16'd139,  1'b0, 32'd105084,   "u_756x139"});
    dir_q.push_back('{16'd342,  16'd939,  1'b0, 32'd321138,   "u_342x939"});
    dir_q.push_back('{16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF, "s_m1x1"});
    dir_q.push_back('{16'h8000, 16'h8000, 1'b1, 32'h40000000, "s_min2"});
    dir_q.push_back('{16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, "s_minxmax"});
    dir_q.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, "s_m1xm1"});
    dir_q.push_back('{16'h0000, 16'h1234, 1'b1, 32'h00000000, "s_zero"});

    foreach (dir_q[i]) begin
      run_op(dir_q[i].a, dir_q[i].b, dir_q[i].s, 0, 64'(dir_q[i].p), dir_q[i].tag);
    end

    // Backpressure with noisy in_valid during DONE.
    run_op(16'h1234, 16'h5678, 1'b0, 5, 64'h0626_0060, "bp_5");

    // Abort at BUSY step 2 with an asynchronous reset.
    @(negedge clk);
    A = 16'h1234; B = 16'h5678; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_P", 64'(P), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'd3, 16'd5, 1'b0, 0, 64'd15, "post_rst_3x5");

    // Randomized operations with extremes mixed in and random stalls.
    for (int i = 0; i < N_RND; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       ra = 16'h8000;
        1:       rb = 16'hFFFF;
        2:       ra = 16'h0000;
        default: ra = ra;
      endcase
      run_op(ra, rb, rs, $urandom_range(0, 2), ref_prod(ra, rb, rs), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
